// File: rtl/sm_frame_max_pkg.sv
// Shared definitions for the sign-magnitude frame-maximum stage:
// sample width, the negative-zero pattern, FSM encodings and the normaliser.
package sm_frame_max_pkg;

  localparam int         SM_W        = 4;
  localparam logic [3:0] SM_NEG_ZERO = 4'b1000;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // -0 folds onto +0 so the two compare equal downstream
  function automatic logic [SM_W-1:0] sm_norm(input logic [SM_W-1:0] x);
    logic [SM_W-1:0] y;
    y = (x == SM_NEG_ZERO) ? 4'b0000 : x;
    return y;
  endfunction

endpackage

// File: rtl/sm_gt.sv
// Sign-magnitude strict greater-than: positive beats negative, larger positive
// magnitude wins, smaller negative magnitude wins. Inputs must be normalised.
module sm_gt
  import sm_frame_max_pkg::*;
(
  input  logic [SM_W-1:0] a,
  input  logic [SM_W-1:0] b,
  output logic            gt
);

  // ordering decision
  always_comb begin
    gt = 1'b0;
    if (a[3] != b[3]) begin
      gt = ~a[3];
    end else if (a[3] == 1'b0) begin
      gt = (a[2:0] > b[2:0]);
    end else begin
      gt = (a[2:0] < b[2:0]);
    end
  end

endmodule

// File: rtl/sm_frame_max.sv
// Frame maximum tracker: accumulates up to N sign-magnitude samples, then
// holds max, first index of max and sample count on a valid/ready output.
module sm_frame_max
  import sm_frame_max_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SM_W-1:0] in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SM_W-1:0] out_max,
  output logic [CW-1:0]   out_idx,
  output logic [CW-1:0]   out_cnt
);

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW:0]   N_W     = N[CW:0];

  state_t          state_r, state_nx;
  logic [CW-1:0]   count_r, count_nx;
  logic [SM_W-1:0] max_r, max_nx;
  logic [CW-1:0]   idx_r, idx_nx;

  logic            accept_s;
  logic [SM_W-1:0] sample_s;
  logic            gt_s;
  logic [CW:0]     count_inc_s;
  logic            close_s;

  assign in_ready    = (state_r == ST_ACC) & ~reset;
  assign accept_s    = in_valid & in_ready;
  assign sample_s    = sm_norm(in_data);
  // one extra bit so N == 2**CW still detects the final sample
  assign count_inc_s = {1'b0, count_r} + {1'b0, CNT_ONE};
  assign close_s     = (count_inc_s == N_W) | in_last;

  sm_gt u_gt (
    .a  (sample_s),
    .b  (max_r),
    .gt (gt_s)
  );

  // next-state and datapath update
  always_comb begin
    state_nx = state_r;
    count_nx = count_r;
    max_nx   = max_r;
    idx_nx   = idx_r;
    case (state_r)
      ST_ACC: begin
        if (accept_s) begin
          if (count_r == {CW{1'b0}}) begin
            max_nx = sample_s;
            idx_nx = {CW{1'b0}};
          end else if (gt_s) begin
            max_nx = sample_s;
            idx_nx = count_r;
          end else begin
            max_nx = max_r;
          end
          count_nx = count_inc_s[CW-1:0];
          if (close_s) begin
            state_nx = ST_HOLD;
          end else begin
            state_nx = ST_ACC;
          end
        end else begin
          state_nx = ST_ACC;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_nx = ST_ACC;
          count_nx = {CW{1'b0}};
        end else begin
          state_nx = ST_HOLD;
        end
      end
      default: begin
        state_nx = ST_ACC;
        count_nx = {CW{1'b0}};
      end
    endcase
  end

  // state and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_ACC;
      count_r <= {CW{1'b0}};
      max_r   <= 4'b0000;
      idx_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nx;
      count_r <= count_nx;
      max_r   <= max_nx;
      idx_r   <= idx_nx;
    end
  end

  assign out_valid = (state_r == ST_HOLD);
  assign out_max   = max_r;
  assign out_idx   = idx_r;
  assign out_cnt   = count_r;

endmodule

// File: tb/tb_sm_frame_max.sv
// Randomised and directed bench for sm_frame_max against a frame-level
// reference model that ranks samples by their signed numeric value.
module tb_sm_frame_max;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          in_valid  = 1'b0;
  logic [3:0]    in_data   = 4'h0;
  logic          in_last   = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [3:0]    out_max;
  logic [CW-1:0] out_idx;
  logic [CW-1:0] out_cnt;

  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;

  logic [3:0]    frame_q[$];
  bit            holding = 1'b0;
  logic [3:0]    m_max   = 4'h0;
  logic [CW-1:0] m_idx   = '0;
  logic [CW-1:0] m_cnt   = '0;

  always #5 clk = ~clk;

  sm_frame_max #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .out_cnt   (out_cnt)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sm_val(input logic [3:0] x);
    int m;
    m = int'(x[2:0]);
    return x[3] ? -m : m;
  endfunction

  task automatic close_frame();
    int best;
    best = 0;
    for (int i = 1; i < frame_q.size(); i++)
      if (sm_val(frame_q[i]) > sm_val(frame_q[best])) best = i;
    m_max = frame_q[best];
    m_idx = CW'(best);
    m_cnt = CW'(frame_q.size());
    holding = 1'b1;
    frame_q.delete();
  endtask

  // one clock cycle: drive, check against model, advance model
  task automatic step(input logic v, input logic [3:0] d, input logic l,
                      input logic r, input logic rs);
    bit acc;
    bit rel;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; out_ready = r; reset = rs;
    #1;
    if (armed) begin
      check_eq("in_ready", {7'd0, in_ready}, {7'd0, (!holding && !rs)});
      check_eq("out_valid", {7'd0, out_valid}, {7'd0, holding});
      if (holding) begin
        check_eq("out_max", {4'd0, out_max}, {4'd0, m_max});
        check_eq("out_idx", {4'd0, out_idx}, {4'd0, m_idx});
        check_eq("out_cnt", {4'd0, out_cnt}, {4'd0, m_cnt});
      end
    end
    acc = v && !holding && !rs;
    rel = holding && r && !rs;
    if (rs) begin
      holding = 1'b0;
      frame_q.delete();
    end else if (rel) begin
      holding = 1'b0;
    end else if (acc) begin
      frame_q.push_back((d == 4'h8) ? 4'h0 : d);
      if (frame_q.size() == N || l) close_frame();
    end
    @(posedge clk);
    armed = 1'b1;
  endtask

  // literal expectations for directed frames, read just after the edge
  task automatic expect_result(input string tag, input logic [3:0] mx,
                               input logic [3:0] ix, input logic [3:0] cn);
    #2;
    check_eq({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
    check_eq({tag, "_max"}, {4'd0, out_max}, {4'd0, mx});
    check_eq({tag, "_idx"}, {4'd0, out_idx}, {4'd0, ix});
    check_eq({tag, "_cnt"}, {4'd0, out_cnt}, {4'd0, cn});
  endtask

  task automatic expect_idle(input string tag);
    #2;
    check_eq(tag, {7'd0, out_valid}, 8'd0);
  endtask

  initial begin
    logic [3:0] full_f[8];
    logic [3:0] neg_f[4];
    full_f = '{4'h2, 4'h5, 4'hB, 4'h7, 4'h7, 4'h0, 4'h9, 4'h4};
    neg_f  = '{4'hE, 4'hA, 4'hF, 4'hA};

    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    expect_idle("reset_idle");

    // full frame with the consumer always ready
    foreach (full_f[i]) step(1'b1, full_f[i], 1'b0, 1'b1, 1'b0);
    expect_result("full", 4'h7, 4'd3, 4'd8);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // all negative, early close
    foreach (neg_f[i]) step(1'b1, neg_f[i], (i == 3), 1'b0, 1'b0);
    expect_result("neg", 4'hA, 4'd1, 4'd4);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // negative zero, then backpressure with new data offered
    step(1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h8, 1'b1, 1'b0, 1'b0);
    expect_result("negzero", 4'h0, 4'd0, 4'd3);
    for (int i = 0; i < 5; i++) step(1'b1, 4'($urandom), 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
    expect_result("bp_next", 4'h6, 4'd0, 4'd2);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // single-sample frame
    step(1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
    expect_result("single", 4'h3, 4'd0, 4'd1);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // reset mid-frame and in HOLD
    step(1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    expect_idle("rst_mid");
    step(1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    expect_idle("rst_hold");
    step(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
    expect_result("post_rst", 4'h2, 4'd1, 4'd2);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 3) != 0), 4'($urandom),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 59) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sm_frame_max.md
Name: sm_frame_max

Overview:
- Streaming stage that consumes 4-bit sign-magnitude samples (bit 3 = sign, bits 2:0 = magnitude) one per handshake.
- Tracks the running maximum of each frame using the same ordering as the sign-magnitude comparator stage, plus the index of that maximum.
- Frames close after N samples or on an early `in_last`; the result is then presented on a valid/ready output.
- Sits downstream of the sample source and upstream of the result consumer; the ordering logic is the only combinational core.

Parameters:
- N, 8, maximum samples per frame (2..16)
- CW, 4, width of count/index fields; must satisfy 2^CW >= N

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  sample present
- in_ready  out  1  stage accepts sample this cycle
- in_data  in  4  sign-magnitude sample
- in_last  in  1  qualifies in_data as final sample of frame (early close)
- out_valid  out  1  frame result present
- out_ready  in  1  consumer takes result this cycle
- out_max  out  4  frame maximum, sign-magnitude, -0 normalised to +0
- out_idx  out  CW  0-based position of first occurrence of the maximum
- out_cnt  out  CW  number of samples in the frame (1..N)

Behaviour:
- Accept = in_valid & in_ready; release = out_valid & out_ready.
- States: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1). There is no IDLE; an empty frame never produces output.
- Reset (reset=1 at a clk edge):
  - state<=ACC; count, max, idx <= 0; out_valid=0.
  - in_ready is 0 while reset is high, then 1 from the first cycle after reset.
  - Reset mid-frame or in HOLD discards all partial or held results with no output.
- Normalisation: 4'b1000 (-0) is converted to 4'b0000 on accept, before comparison, so -0 and +0 compare equal.
- Ordering:
  - Positive > negative.
  - Two positives: larger magnitude wins.
  - Two negatives: smaller magnitude wins.
- ACC, accept with count==0: max<=sample, idx<=0, count<=1.
- ACC, accept with count>0: if sample strictly greater than max, then max<=sample and idx<=count. Equal values keep the earlier idx. count<=count+1.
- Frame close on an accept where count+1==N or in_last=1: next state HOLD. out_cnt=count+1, and out_max/out_idx include that sample.
- Latency: out_valid rises on the cycle after the closing accept.
- HOLD:
  - out_max, out_idx, out_cnt are stable until release; in_valid/in_data are ignored.
  - On release: state<=ACC, count<=0, and in_ready=1 on the next cycle. One bubble per frame; no same-cycle bypass.
- in_last on a count==N-1 accept is the same single close event, not a double close.
- Outputs out_max/out_idx/out_cnt are don't-care while out_valid=0. The implementation drives the internal registers directly.
- Every output is a function of registered state only, apart from in_ready's dependence on reset. There is no combinational path from in_* to out_*.

Decomposition:
- Shared package/header:
  - SM_W=4
  - SM_NEG_ZERO=4'b1000
  - state encodings ST_ACC=1'b0, ST_HOLD=1'b1
- Sub-module sm_gt:
  - Combinational, inputs a[3:0] and b[3:0], output gt=1 when a>b under the ordering above.
  - Inputs are assumed already normalised.
  - Verified standalone, exhaustively over 256 pairs.
- Top holds the FSM, count, max/idx registers and the normaliser.

Test Plan:
- Full frame, N=8: samples 2,5,-3,7,7,0,-1,4 (hex 2,5,B,7,7,0,9,4) with out_ready=1. Expect out_valid one cycle after the 8th accept, out_max=7, out_idx=3, out_cnt=8, then in_ready=1 the cycle after release.
- All negative: -6,-2,-7,-2 with in_last on the 4th (E,A,F,A). Expect out_max=A (-2), out_idx=1, out_cnt=4.
- Negative zero: frame 8,9,8 (-0,-1,-0) with in_last. Expect out_max=0 (normalised), out_idx=0, out_cnt=3.
- Backpressure: close a frame, hold out_ready=0 for 5 cycles while driving in_valid=1 with new data. Expect in_ready=0, outputs stable and no samples consumed. Raise out_ready and expect release, then the next frame's first accept one cycle later.
- Single-sample frame: first accept 3 with in_last=1. Expect out_max=3, out_idx=0, out_cnt=1.
- Reset mid-operation: assert reset after 3 accepts, then in HOLD of another frame. Expect out_valid=0 and no result for either. The following clean frame 1,2 with in_last yields out_max=2, out_idx=1, out_cnt=2.
